// File: rtl/param_seq_det_pkg.sv
// Shared constants and helpers for the parameterised serial sequence detector.
package param_seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    // Bits needed to hold a length value in the range 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/param_sequence_detector_counter.sv
// Saturating match counter; a clear takes priority over an increment.
module seq_match_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/param_sequence_detector.sv
// Runtime-configurable serial pattern detector: a history shift register is
// compared against the pattern under a length mask, with optional overlap.
module param_sequence_detector
    import param_seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b0110),
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        data_valid,
    input  logic                        data_in,
    input  logic                        cfg_we,
    input  logic [MAX_LEN-1:0]          cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]   cfg_len,
    input  logic                        cfg_overlap,
    input  logic                        count_clr,
    output logic                        detected,
    output logic [CNT_W-1:0]            match_count,
    output logic                        cfg_err
);

    localparam int                LEN_W = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0]  FULL  = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_fill;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_detected;
    logic               r_cfg_err;

    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_next;
    logic               w_accept;
    logic               w_cfg_ok;
    logic               w_match;

    // A configuration write always owns the cycle; the data bit is dropped.
    assign w_accept    = data_valid && !cfg_we;
    assign w_cfg_ok    = (cfg_len != '0) && (cfg_len <= FULL);
    assign w_hist_next = {r_hist[MAX_LEN-2:0], data_in};
    assign w_fill_next = (r_fill == FULL) ? r_fill : r_fill + 1'b1;

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        localparam logic [LEN_W-1:0] IDX = LEN_W'(gi);
        assign w_mask[gi] = (IDX < r_len);
    end

    assign w_match = w_accept && (w_fill_next >= r_len)
                  && (((w_hist_next ^ r_pattern) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist     <= '0;
            r_fill     <= '0;
            r_pattern  <= RST_PATTERN;
            r_len      <= LEN_W'(RST_LEN);
            r_overlap  <= RST_OVERLAP;
            r_detected <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_detected <= 1'b0;
            r_cfg_err  <= 1'b0;
            if (cfg_we) begin
                if (w_cfg_ok) begin
                    r_pattern <= cfg_pattern;
                    r_len     <= cfg_len;
                    r_overlap <= cfg_overlap;
                    r_hist    <= '0;
                    r_fill    <= '0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else if (data_valid) begin
                r_hist     <= w_hist_next;
                // Non-overlap mode forces the next match to use fresh bits only.
                r_fill     <= (w_match && !r_overlap) ? '0 : w_fill_next;
                r_detected <= w_match;
            end
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_match),
        .clr   (count_clr),
        .count (match_count)
    );

    assign detected = r_detected;
    assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model of the detector's matching rules.
module tb_param_sequence_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_valid;
    logic       data_in;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       count_clr;

    logic        detected,  cfg_err;
    logic [15:0] match_count;
    logic        detected2, cfg_err2;
    logic [1:0]  match_count2;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    bit         q[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    int         m_cnt2;
    logic       exp_det;
    logic       exp_err;

    always #5 clk = ~clk;

    param_sequence_detector dut (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .detected(detected), .match_count(match_count), .cfg_err(cfg_err)
    );

    param_sequence_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .detected(detected2), .match_count(match_count2), .cfg_err(cfg_err2)
    );

    // Model: keep the accepted bits since the last reset/config/non-overlap
    // match; a match is the newest len bits equal to pattern, MSB first.
    function automatic void model_update();
        bit hit;
        hit     = 1'b0;
        exp_det = 1'b0;
        exp_err = 1'b0;
        if (!reset) begin
            q.delete();
            m_pat = 8'b0110; m_len = 4; m_ovl = 1'b1;
            m_cnt = 0; m_cnt2 = 0;
            return;
        end
        if (cfg_we) begin
            if (cfg_len >= 1 && cfg_len <= 8) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                q.delete();
            end else begin
                exp_err = 1'b1;
            end
        end else if (data_valid) begin
            q.push_back(data_in);
            if (q.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
            end
            if (hit) begin
                exp_det = 1'b1;
                if (!m_ovl) q.delete();
            end
            while (q.size() > 8) void'(q.pop_front());
        end
        if (count_clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        data_valid = 1'b0; data_in = 1'b0; cfg_we = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        tick();
        cfg_we = 1'b0;
        n_vec++;
        if (cfg_err !== exp_err || detected !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_write len=%0d: cfg_err=%b det=%b required cfg_err=%b det=0",
                     len, cfg_err, detected, exp_err);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        n_vec++;
        if ({detected, cfg_err, match_count, match_count2} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_state: det=%b err=%b cnt=%0d cnt2=%0d required all 0",
                     detected, cfg_err, match_count, match_count2);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_basic_stream();
        logic [6:0] s = 7'b0110110;
        int pulses = 0;
        do_reset();
        data_valid = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            data_in = s[i];
            tick();
            pulses += int'(detected);
            n_vec++;
            if (detected !== exp_det || match_count !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL basic bit%0d: det=%b cnt=%0d required det=%b cnt=%0d",
                         7 - i, detected, match_count, exp_det, m_cnt);
            end
        end
        data_valid = 1'b0;
        n_vec++;
        if (pulses != 2 || match_count !== 16'd2) begin
            n_err++;
            $display("FAIL basic_total: pulses=%0d cnt=%0d required 2/2", pulses, match_count);
        end
    endtask

    task automatic test_pattern_101();
        logic [4:0] s = 5'b10101;
        int pulses;
        do_reset();
        for (int m = 1; m >= 0; m--) begin
            configure(8'b101, 4'd3, 1'(m));
            pulses = 0;
            data_valid = 1'b1;
            for (int i = 4; i >= 0; i--) begin
                data_in = s[i];
                tick();
                pulses += int'(detected);
                n_vec++;
                if (detected !== exp_det) begin
                    n_err++;
                    $display("FAIL p101 ovl=%0d bit%0d: det=%b required %b", m, 5 - i, detected, exp_det);
                end
            end
            data_valid = 1'b0;
            n_vec++;
            if (pulses != ((m == 1) ? 2 : 1)) begin
                n_err++;
                $display("FAIL p101_total ovl=%0d: pulses=%0d required %0d", m, pulses, (m == 1) ? 2 : 1);
            end
        end
    endtask

    task automatic test_gaps();
        logic [3:0] s = 4'b0110;
        int pulses = 0;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            data_valid = 1'b1; data_in = s[i];
            tick();
            pulses += int'(detected);
            n_vec++;
            if (detected !== exp_det || detected !== (i == 0)) begin
                n_err++;
                $display("FAIL gaps bit%0d: det=%b required %b", 4 - i, detected, (i == 0));
            end
            data_valid = 1'b0; data_in = ~data_in;
            for (int g = 0; g < 3 && i > 0; g++) begin
                tick();
                n_vec++;
                if (detected !== 1'b0 || match_count !== 16'(m_cnt)) begin
                    n_err++;
                    $display("FAIL gaps_idle: det=%b cnt=%0d required 0/%0d", detected, match_count, m_cnt);
                end
            end
        end
        tick();
        n_vec++;
        if (pulses != 1 || detected !== 1'b0) begin
            n_err++;
            $display("FAIL gaps_total: pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_bad_cfg();
        logic [3:0] s = 4'b0110;
        int pulses = 0;
        do_reset();
        configure(8'hFF, 4'd0, 1'b0);
        n_vec++;
        if (cfg_err !== 1'b1) begin
            n_err++;
            $display("FAIL bad_cfg_len0: cfg_err=%b required 1", cfg_err);
        end
        configure(8'hFF, 4'd9, 1'b0);
        data_valid = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            data_in = s[i];
            tick();
            pulses += int'(detected);
            n_vec++;
            if (cfg_err !== 1'b0 || detected !== exp_det) begin
                n_err++;
                $display("FAIL bad_cfg_stream: err=%b det=%b required 0/%b", cfg_err, detected, exp_det);
            end
        end
        data_valid = 1'b0;
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL bad_cfg_total: pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_saturate();
        logic [15:0] s = 16'b0110110110110110;
        do_reset();
        data_valid = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            data_in = s[i];
            tick();
            n_vec++;
            if (match_count2 !== 2'(m_cnt2) || detected2 !== exp_det) begin
                n_err++;
                $display("FAIL sat bit%0d: cnt2=%0d det2=%b required %0d/%b",
                         16 - i, match_count2, detected2, m_cnt2, exp_det);
            end
        end
        data_valid = 1'b0;
        n_vec++;
        if (match_count2 !== 2'd3 || match_count !== 16'd5) begin
            n_err++;
            $display("FAIL sat_total: cnt2=%0d cnt=%0d required 3/5", match_count2, match_count);
        end
        // Clear coincident with a match: the clear must win.
        data_valid = 1'b1; data_in = 1'b1; tick(); tick();
        data_in = 1'b0; count_clr = 1'b1;
        tick();
        count_clr = 1'b0; data_valid = 1'b0;
        n_vec++;
        if (match_count2 !== 2'd0 || match_count !== 16'd0 || detected !== 1'b1) begin
            n_err++;
            $display("FAIL clr_win: cnt2=%0d cnt=%0d det=%b required 0/0/1",
                     match_count2, match_count, detected);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] s = 3'b011;
        logic [3:0] t = 4'b0110;
        int pulses = 0;
        do_reset();
        data_valid = 1'b1;
        for (int i = 2; i >= 0; i--) begin data_in = s[i]; tick(); end
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            data_in = t[i];
            tick();
            pulses += int'(detected);
            n_vec++;
            if (detected !== exp_det || detected !== (i == 0)) begin
                n_err++;
                $display("FAIL reset_mid bit%0d: det=%b required %b", 4 - i, detected, (i == 0));
            end
        end
        data_valid = 1'b0;
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL reset_mid_total: pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_len1_and_collision();
        do_reset();
        configure(8'b1, 4'd1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            data_valid = 1'($urandom_range(0, 3) != 0);
            data_in    = 1'($urandom);
            // Config write in the same cycle as data: bit must be discarded.
            cfg_we = (i == 12); cfg_pattern = 8'b1; cfg_len = 4'd1; cfg_overlap = 1'b0;
            tick();
            n_vec++;
            if (detected !== exp_det || match_count !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL len1 cyc%0d: det=%b cnt=%0d required %b/%0d",
                         i, detected, match_count, exp_det, m_cnt);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) != 0);
            cfg_we      = ($urandom_range(0, 39) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom);
            count_clr   = ($urandom_range(0, 99) == 0);
            data_valid  = ($urandom_range(0, 9) < 7);
            data_in     = 1'($urandom);
            tick();
            n_vec++;
            if ({detected, cfg_err, match_count, detected2, cfg_err2, match_count2} !==
                {exp_det, exp_err, 16'(m_cnt), exp_det, exp_err, 2'(m_cnt2)}) begin
                n_err++;
                $display("FAIL random cyc%0d: det=%b err=%b cnt=%0d cnt2=%0d required %b/%b/%0d/%0d",
                         i, detected, cfg_err, match_count, match_count2,
                         exp_det, exp_err, m_cnt, m_cnt2);
            end
        end
        idle_inputs();
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_basic_stream();
        test_pattern_101();
        test_gaps();
        test_bad_cfg();
        test_saturate();
        test_reset_mid();
        test_len1_and_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_sequence_detector.md
PARAM_SEQUENCE_DETECTOR -- requirements
Module: param_sequence_detector

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, range 2..32.
REQ-002 Parameter CNT_W, default 16: width of the match counter.
REQ-003 Parameter RST_PATTERN, default 'b0110 (MAX_LEN bits): pattern loaded at reset.
REQ-004 Parameter RST_LEN, default 4: pattern length loaded at reset.
REQ-005 Parameter RST_OVERLAP, default 1: overlap mode loaded at reset.
REQ-006 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-low reset.
REQ-008 Port data_valid, input, 1: data_in sampled only when high.
REQ-009 Port data_in, input, 1: serial input bit.
REQ-010 Port cfg_we, input, 1: configuration write strobe.
REQ-011 Port cfg_pattern, input, MAX_LEN: new pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-012 Port cfg_len, input, $clog2(MAX_LEN+1): new pattern length.
REQ-013 Port cfg_overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-014 Port count_clr, input, 1: synchronous clear of match_count.
REQ-015 Port detected, output, 1: registered one-cycle match pulse.
REQ-016 Port match_count, output, CNT_W: saturating count of matches.
REQ-017 Port cfg_err, output, 1: registered one-cycle pulse on a rejected configuration write.

Function
REQ-018 History: MAX_LEN-bit shift register; on each accepted bit, hist <= {hist[MAX_LEN-2:0], data_in}, so hist[0] is the newest bit.
REQ-019 Fill counter: 0..MAX_LEN; increments on each accepted bit and saturates at MAX_LEN.
REQ-020 Match condition: data_valid high, fill_next >= len, and next_hist[i] == pattern[i] for every i < len; bits at or above len are ignored.
REQ-021 detected is registered: it is high for exactly the one cycle following the clock edge that samples the final pattern bit, and is otherwise 0.
REQ-022 Overlap mode 1: after a match, fill keeps fill_next, so a suffix of the match can start the next match.
REQ-023 Overlap mode 0: after a match, fill is set to 0, so the next match needs len fresh bits.
REQ-024 data_valid low: history, fill and match_count hold, and detected is 0.
REQ-025 cfg_we with 1 <= cfg_len <= MAX_LEN: latch pattern, len and overlap; clear history and fill; detected 0 next cycle.
REQ-026 cfg_we with cfg_len == 0 or cfg_len > MAX_LEN: configuration is unchanged, history is unchanged, and cfg_err pulses for one cycle.
REQ-027 cfg_we together with data_valid: the configuration write wins; the data bit is discarded and no match is evaluated.
REQ-028 match_count increments by 1 per match and saturates at all-ones (no wrap).
REQ-029 count_clr together with a match: the clear wins and match_count becomes 0.
REQ-030 A length-1 pattern is legal; with overlap 0 and pattern 1, every accepted 1 produces a match.

Reset
REQ-031 When reset is low at a clock edge: history 0, fill 0, pattern RST_PATTERN, len RST_LEN, overlap RST_OVERLAP, detected 0, match_count 0, cfg_err 0.
REQ-032 Reset asserted mid-stream discards any partial match; detection needs len bits accepted after reset is released.

Structure
REQ-033 Package param_seq_det_pkg holds the default MAX_LEN/CNT_W constants and the length-width localparam function.
REQ-034 Sub-module seq_match_counter (parameter CNT_W; inputs inc and clr; saturating; clr priority) implements match_count.
REQ-035 Pattern compare is a masked equality, not an explicit per-pattern FSM; the only state is history, fill and the config registers.

Verification
REQ-036 After reset, stream 0,1,1,0,1,1,0 with data_valid high: detected pulses after bit 4 and bit 7; match_count = 2.
REQ-037 Configure pattern 101, len 3: with overlap 1, stream 1,0,1,0,1 gives 2 pulses; with overlap 0, the same stream gives 1 pulse (after bit 3).
REQ-038 Default pattern sent as 0,1,1,0 with data_valid low for 3 cycles between each bit: exactly 1 pulse, after the fourth valid bit; no pulse during the gaps.
REQ-039 cfg_we with cfg_len = 0, then stream 0110: cfg_err pulses once and detected still pulses once (config unchanged).
REQ-040 Build with CNT_W = 2, send 5 overlapping 0110 matches: match_count = 3; then count_clr gives 0.
REQ-041 Stream 0,1,1, assert reset for 1 cycle, then send 0: no pulse; a following 1,1,0 also gives no pulse until a full 0110 is received.
